// File: rtl/fma_add_norm_if.sv
// Handshake and data bundle between the fma16 alignment stage, this add/normalize
// stage and the rounding stage.
interface fma_add_norm_if #(
    parameter int NF = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2*NF+1:0]   Pm;
    logic [6:0]        ProdExp;
    logic [3*NF+3:0]   Am;
    logic              ASticky;
    logic              KillProd;
    logic              Ps;
    logic              Zs;
    logic              out_valid;
    logic              out_ready;
    logic [3*NF+4:0]   Mm;
    logic [7:0]        Me;
    logic              Ms;
    logic              Sticky;
    logic              ResZero;

    modport master (
        output in_valid, Pm, ProdExp, Am, ASticky, KillProd, Ps, Zs, out_ready,
        input  in_ready, out_valid, Mm, Me, Ms, Sticky, ResZero
    );

    modport slave (
        input  in_valid, Pm, ProdExp, Am, ASticky, KillProd, Ps, Zs, out_ready,
        output in_ready, out_valid, Mm, Me, Ms, Sticky, ResZero
    );
endinterface

// File: rtl/fma_add_norm.sv
// fma16 add + normalize: stage 1 forms the signed sum magnitude, stage 2
// counts leading zeros and left-normalizes for the rounding stage.
module fma_add_norm #(
    parameter int NF = 10
) (
    input logic           clk,
    input logic           reset,
    fma_add_norm_if.slave bus
);
    localparam int PW    = 2*NF + 2;
    localparam int WW    = 3*NF + 4;
    localparam int SW    = 3*NF + 5;
    localparam int LW    = $clog2(SW + 1);
    localparam int EBIAS = NF + 4;

    logic          s1_valid;
    logic          s2_valid;
    logic          s2_ready;
    logic          in_fire;
    logic          s1_adv;

    // s2 frees up in the same cycle the consumer takes its result, so in_ready
    // sees out_ready combinationally and a full pipe still streams.
    assign s2_ready     = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s2_ready;
    assign in_fire      = bus.in_valid & bus.in_ready;
    assign s1_adv       = s1_valid & s2_ready;
    assign bus.out_valid = s2_valid;

    logic [SW:0]   p_ext;
    logic [SW:0]   a_ext;
    logic [SW:0]   sum;
    logic [SW-1:0] mag;
    logic          inva;
    logic          sum_neg;
    logic          sgn;

    // The sticky behaves as a borrow below window bit 0 when subtracting.
    always_comb begin
        inva  = bus.Ps ^ bus.Zs;
        p_ext = bus.KillProd ? '0 : {{(SW+1-PW){1'b0}}, bus.Pm};
        a_ext = {{(SW+1-WW){1'b0}}, bus.Am};
        if (inva)
            sum = p_ext + ~a_ext + {{SW{1'b0}}, ~bus.ASticky};
        else
            sum = p_ext + a_ext;
        sum_neg = sum[SW];
        mag     = sum_neg ? -sum[SW-1:0] : sum[SW-1:0];
        sgn     = sum_neg ? bus.Zs : (bus.KillProd ? bus.Zs : bus.Ps);
    end

    logic [SW-1:0] s1_mag;
    logic          s1_sgn;
    logic          s1_sticky;
    logic [6:0]    s1_pexp;
    logic          s1_inva;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_mag    <= '0;
            s1_sgn    <= 1'b0;
            s1_sticky <= 1'b0;
            s1_pexp   <= '0;
            s1_inva   <= 1'b0;
        end else begin
            if (in_fire)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
            if (in_fire) begin
                s1_mag    <= mag;
                s1_sgn    <= sgn;
                s1_sticky <= bus.ASticky;
                s1_pexp   <= bus.ProdExp;
                s1_inva   <= inva;
            end
        end
    end

    logic [LW-1:0] lzc;
    logic [SW-1:0] norm;
    logic [7:0]    exp_n;
    logic          mag_zero;

    // Highest set bit wins because the scan runs upward.
    always_comb begin
        lzc = LW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s1_mag[i])
                lzc = LW'(SW - 1 - i);
        end
        mag_zero = (s1_mag == '0);
        norm     = s1_mag << lzc;
        exp_n    = {s1_pexp[6], s1_pexp} + 8'(EBIAS) - {{(8-LW){1'b0}}, lzc};
    end

    // An exact cancellation under round-to-nearest yields +0.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            bus.Mm      <= '0;
            bus.Me      <= '0;
            bus.Ms      <= 1'b0;
            bus.Sticky  <= 1'b0;
            bus.ResZero <= 1'b0;
        end else begin
            if (s1_adv)
                s2_valid <= 1'b1;
            else if (bus.out_ready)
                s2_valid <= 1'b0;
            if (s1_adv) begin
                bus.Sticky <= s1_sticky;
                if (mag_zero) begin
                    bus.Mm      <= '0;
                    bus.Me      <= '0;
                    bus.ResZero <= ~s1_sticky;
                    bus.Ms      <= (~s1_sticky & s1_inva) ? 1'b0 : s1_sgn;
                end else begin
                    bus.Mm      <= norm;
                    bus.Me      <= exp_n;
                    bus.ResZero <= 1'b0;
                    bus.Ms      <= s1_sgn;
                end
            end
        end
    end
endmodule

// File: tb/tb_fma_add_norm.sv
// Bench for fma_add_norm: directed cases with hand-derived results, then random
// traffic scored against an arithmetic reference model.
module tb_fma_add_norm;
    typedef struct packed {
        logic [21:0] pm;
        logic [6:0]  pexp;
        logic [33:0] am;
        logic        asticky;
        logic        killprod;
        logic        ps;
        logic        zs;
    } txn_t;

    typedef struct packed {
        logic [34:0] mm;
        logic [7:0]  me;
        logic        ms;
        logic        sticky;
        logic        reszero;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fma_add_norm_if #(.NF(10)) bus ();
    fma_add_norm #(.NF(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    res_t expq[$];
    res_t rcvq[$];
    int   n_asserts = 0;
    int   n_fails = 0;
    bit   random_ready = 1'b0;

    // Results are taken at the falling edge, when the next rising edge will transfer them.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready)
            rcvq.push_back({bus.Mm, bus.Me, bus.Ms, bus.Sticky, bus.ResZero});
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    function automatic res_t get_out();
        return {bus.Mm, bus.Me, bus.Ms, bus.Sticky, bus.ResZero};
    endfunction

    function automatic res_t mk(logic [34:0] mm, logic [7:0] me, logic ms, logic st, logic rz);
        res_t r;
        r.mm = mm; r.me = me; r.ms = ms; r.sticky = st; r.reszero = rz;
        return r;
    endfunction

    function automatic txn_t mk_txn(logic [21:0] pm, logic [6:0] pexp, logic [33:0] am,
                                    logic ast, logic kp, logic ps, logic zs);
        txn_t t;
        t.pm = pm; t.pexp = pexp; t.am = am; t.asticky = ast;
        t.killprod = kp; t.ps = ps; t.zs = zs;
        return t;
    endfunction

    // Reference: signed integer sum, then normalize by doubling until bit 34 is set.
    function automatic res_t model(txn_t t);
        longint p, a, v, mag;
        int     e;
        logic   sgn;
        res_t   r;
        p = t.killprod ? 64'sd0 : longint'(t.pm);
        a = longint'(t.am);
        if (t.ps ^ t.zs)
            v = p - a - longint'(t.asticky);
        else
            v = p + a;
        if (v < 0) begin
            mag = -v;
            sgn = t.zs;
        end else begin
            mag = v;
            sgn = t.killprod ? t.zs : t.ps;
        end
        r.sticky = t.asticky;
        if (mag == 0) begin
            r.mm = '0;
            r.me = '0;
            r.reszero = !t.asticky;
            r.ms = (r.reszero && (t.ps ^ t.zs)) ? 1'b0 : sgn;
        end else begin
            e = int'($signed(t.pexp)) + 14;
            while (mag < (longint'(1) << 34)) begin
                mag = mag * 2;
                e--;
            end
            r.mm = mag[34:0];
            r.me = e[7:0];
            r.ms = sgn;
            r.reszero = 1'b0;
        end
        return r;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [33:0] raw;
        raw = {2'($urandom), 32'($urandom)};
        t.pm = 22'($urandom);
        t.pexp = 7'($urandom);
        t.am = raw >> $urandom_range(0, 33);
        t.asticky = 1'($urandom_range(0, 1));
        t.killprod = ($urandom_range(0, 7) == 0);
        t.ps = 1'($urandom_range(0, 1));
        t.zs = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0)
            t.am = {12'b0, t.pm};
        return t;
    endfunction

    task automatic drive_txn(input txn_t t);
        bus.Pm = t.pm; bus.ProdExp = t.pexp; bus.Am = t.am; bus.ASticky = t.asticky;
        bus.KillProd = t.killprod; bus.Ps = t.ps; bus.Zs = t.zs;
    endtask

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: got Mm=%h Me=%h Ms=%b St=%b Z=%b, expected Mm=%h Me=%h Ms=%b St=%b Z=%b",
                   tag, got.mm, got.me, got.ms, got.sticky, got.reszero,
                   exp.mm, exp.me, exp.ms, exp.sticky, exp.reszero);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Presents one transaction until accepted; returns the cycles spent.
    task automatic applyStimulus(input txn_t t, input res_t exp, output int waited);
        bit acc;
        bit sampled;
        acc = 1'b0;
        waited = 0;
        drive_txn(t);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            if (random_ready)
                bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            sampled = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
            acc = sampled;
        end
        bus.in_valid = 1'b0;
        check_bit("accept_timeout", acc, 1'b1);
        if (acc)
            expq.push_back(exp);
    endtask

    task automatic checkOutput(input string tag);
        res_t got;
        res_t exp;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 200 && rcvq.size() < expq.size(); c++) begin
            @(posedge clk);
            #1;
        end
        check_int({tag, "_count"}, rcvq.size(), expq.size());
        while (expq.size() > 0 && rcvq.size() > 0) begin
            got = rcvq.pop_front();
            exp = expq.pop_front();
            check_res(tag, got, exp);
        end
        expq.delete();
        rcvq.delete();
    endtask

    initial begin
        int   w;
        int   total;
        int   idx;
        bit   sampled;
        bit   seen;
        txn_t t;
        txn_t bp[4];

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive_txn(mk_txn(22'h0, 7'd0, 34'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_res("reset_outputs", get_out(), '0);
        reset = 1'b0;

        // 1.0*1.0 + 1.0, also checking the two-edge latency
        applyStimulus(mk_txn(22'h100000, 7'd15, 34'h100000, 1'b0, 1'b0, 1'b0, 1'b0),
                      mk(35'h4_0000_0000, 8'd16, 1'b0, 1'b0, 1'b0), w);
        check_bit("latency_first_edge", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_bit("latency_second_edge", bus.out_valid, 1'b1);
        checkOutput("one_plus_one");

        applyStimulus(mk_txn(22'h100000, 7'd15, 34'h100000, 1'b0, 1'b0, 1'b0, 1'b1),
                      mk(35'h0, 8'd0, 1'b0, 1'b0, 1'b1), w);
        checkOutput("exact_cancel");

        applyStimulus(mk_txn(22'h100000, 7'd15, 34'h200000, 1'b0, 1'b0, 1'b0, 1'b1),
                      mk(35'h4_0000_0000, 8'd15, 1'b1, 1'b0, 1'b0), w);
        checkOutput("negative_result");

        applyStimulus(mk_txn(22'h100000, 7'd15, 34'h0, 1'b1, 1'b0, 1'b0, 1'b1),
                      mk(35'h7_FFFF_8000, 8'd14, 1'b0, 1'b1, 1'b0), w);
        checkOutput("sticky_borrow");

        applyStimulus(mk_txn(22'h3ABCDE, 7'd15, 34'h100000, 1'b0, 1'b1, 1'b1, 1'b0),
                      mk(35'h4_0000_0000, 8'd15, 1'b0, 1'b0, 1'b0), w);
        checkOutput("kill_product");

        applyStimulus(mk_txn(22'h12345, 7'd3, 34'h0, 1'b1, 1'b1, 1'b0, 1'b0),
                      mk(35'h0, 8'd0, 1'b0, 1'b1, 1'b0), w);
        checkOutput("zero_with_sticky");

        total = 0;
        for (int i = 0; i < 8; i++) begin
            t = rand_txn();
            applyStimulus(t, model(t), w);
            total += w;
        end
        check_int("full_throughput_cycles", total, 8);
        checkOutput("back_to_back");

        // Four transactions against a stalled consumer
        for (int i = 0; i < 4; i++)
            bp[i] = rand_txn();
        bus.out_ready = 1'b0;
        idx = 0;
        drive_txn(bp[0]);
        bus.in_valid = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            sampled = bus.in_ready;
            @(posedge clk);
            #1;
            if (sampled) begin
                expq.push_back(model(bp[idx]));
                idx++;
                if (idx < 4) drive_txn(bp[idx]);
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid && expq.size() > 0)
                check_res("backpressure_hold", get_out(), expq[0]);
        end
        check_int("backpressure_accepted", idx, 2);
        check_bit("backpressure_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            sampled = bus.in_ready;
            @(posedge clk);
            #1;
            if (sampled) begin
                expq.push_back(model(bp[idx]));
                idx++;
                if (idx < 4) drive_txn(bp[idx]);
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check_int("backpressure_all_accepted", idx, 4);
        checkOutput("backpressure_drain");

        random_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            t = rand_txn();
            applyStimulus(t, model(t), w);
        end
        random_ready = 1'b0;
        checkOutput("random_traffic");

        // Reset with two transactions in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = rand_txn();
            applyStimulus(t, model(t), w);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_bit("midreset_out_valid", bus.out_valid, 1'b0);
        check_bit("midreset_in_ready", bus.in_ready, 1'b1);
        check_res("midreset_outputs", get_out(), '0);
        expq.delete();
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check_bit("midreset_no_stale_valid", seen, 1'b0);
        check_int("midreset_no_stale_result", rcvq.size(), 0);

        applyStimulus(mk_txn(22'h100000, 7'd15, 34'h100000, 1'b0, 1'b0, 1'b0, 1'b0),
                      mk(35'h4_0000_0000, 8'd16, 1'b0, 1'b0, 1'b0), w);
        checkOutput("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
